// File: rtl/mips_hazard_pkg.sv
// ---------------------------------------------------------------------------
// mips_hazard_pkg
// Shared types and constants for the pipeline hazard/stall unit.
//   md_state_e          : mult/div sequencing state (RUN, MD_WAIT)
//   MD_LATENCY_DEFAULT  : default number of cycles a mult/div occupies HI/LO
// ---------------------------------------------------------------------------
package mips_hazard_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

   localparam int MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/md_latency_counter.sv
// ---------------------------------------------------------------------------
// md_latency_counter
// Down-counter that times one mult/div operation.  Loading presets the count
// to MD_LATENCY-1 so that, together with the cycle in which the count reaches
// zero, the owning FSM spends exactly MD_LATENCY cycles waiting.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, clears the count
//   i_load  : preset count to MD_LATENCY-1 (operation launched this cycle)
//   i_dec   : decrement by one while the operation is in flight
//   o_zero  : count is zero (last wait cycle, or idle)
// ---------------------------------------------------------------------------
module md_latency_counter #(
   parameter int MD_LATENCY = 32
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   localparam int CNT_W = $clog2(MD_LATENCY);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_dec && (r_cnt != '0)) begin
         // Saturate at zero so an idle counter never wraps.
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Detects load-use and HI/LO (mult/div) hazards for the ID stage, handles
// taken-branch flushes, and sequences the multi-cycle mult/div unit.
// Ports:
//   clk_i, rst_i      : clock and synchronous active-high reset
//   ID_RS, ID_RT      : source register fields of the ID instruction
//   ID_MulDiv         : ID instruction is mult/multu/div/divu
//   ID_UsesHILO       : ID instruction is mfhi/mflo/mthi/mtlo
//   EX_MemRead, EX_RT : load in EX and its destination register
//   EX_BranchTaken    : branch/jump in EX resolved taken
//   PC_Write          : PC may update
//   IFID_Write        : IF/ID register may load
//   IFID_Flush        : IF/ID register loads a nop
//   IDEX_Flush        : ID/EX control fields zeroed (bubble)
//   MD_Start          : one-cycle launch pulse for the mult/div unit
//   MD_Busy           : mult/div unit occupied
// ---------------------------------------------------------------------------
module hazard_stall_unit
   import mips_hazard_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] ID_RS,
   input  logic [4:0] ID_RT,
   input  logic       ID_MulDiv,
   input  logic       ID_UsesHILO,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_RT,
   input  logic       EX_BranchTaken,
   output logic       PC_Write,
   output logic       IFID_Write,
   output logic       IFID_Flush,
   output logic       IDEX_Flush,
   output logic       MD_Start,
   output logic       MD_Busy
);

   md_state_e r_state;
   md_state_e w_next_state;
   logic      w_lu;
   logic      w_mh;
   logic      w_cnt_zero;

   // $zero is never a real dependency, so a load into it cannot stall.
   assign w_lu = EX_MemRead && (EX_RT != 5'd0) &&
                 ((EX_RT == ID_RS) || (EX_RT == ID_RT));

   assign w_mh = (r_state == MD_WAIT) && (ID_MulDiv || ID_UsesHILO);

   assign MD_Busy = (r_state == MD_WAIT);

   md_latency_counter #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_cnt (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_load (MD_Start),
      .i_dec  (MD_Busy),
      .o_zero (w_cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      PC_Write     = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Flush   = 1'b0;
      MD_Start     = 1'b0;

      // A taken branch kills the ID instruction, so any stall it would have
      // caused is moot; the front end keeps moving to the branch target.
      if (EX_BranchTaken) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (w_lu || w_mh) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
      end

      case (r_state)
         RUN: begin
            if (ID_MulDiv && !w_lu && !EX_BranchTaken) begin
               MD_Start     = 1'b1;
               w_next_state = MD_WAIT;
            end
         end
         MD_WAIT: begin
            // An in-flight operation was issued ahead of any branch now in
            // EX, so only the counter ends the wait.
            if (w_cnt_zero) begin
               w_next_state = RUN;
            end
         end
         default: begin
            w_next_state = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit.  Two instances share the stimulus:
// one with MD_LATENCY=4 and one with MD_LATENCY=32.  Output vectors are
// packed as {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy}.
module tb_hazard_stall_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_muldiv, id_useshilo, ex_memread, ex_br;

   logic a_pc, a_ifw, a_iff, a_idf, a_st, a_busy;
   logic b_pc, b_ifw, b_iff, b_idf, b_st, b_busy;

   int n_checks = 0;
   int n_errors = 0;

   // Expected output patterns
   localparam logic [5:0] V_IDLE   = 6'b110000;
   localparam logic [5:0] V_STALL  = 6'b000100;
   localparam logic [5:0] V_BRANCH = 6'b111100;
   localparam logic [5:0] V_START  = 6'b110010;
   localparam logic [5:0] V_BUSY   = 6'b110001;
   localparam logic [5:0] V_MHSTL  = 6'b000101;
   localparam logic [5:0] V_BRBUSY = 6'b111101;

   always #5 clk = ~clk;

   hazard_stall_unit #(.MD_LATENCY(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .ID_RS(id_rs), .ID_RT(id_rt),
      .ID_MulDiv(id_muldiv), .ID_UsesHILO(id_useshilo),
      .EX_MemRead(ex_memread), .EX_RT(ex_rt), .EX_BranchTaken(ex_br),
      .PC_Write(a_pc), .IFID_Write(a_ifw), .IFID_Flush(a_iff),
      .IDEX_Flush(a_idf), .MD_Start(a_st), .MD_Busy(a_busy)
   );

   hazard_stall_unit #(.MD_LATENCY(32)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .ID_RS(id_rs), .ID_RT(id_rt),
      .ID_MulDiv(id_muldiv), .ID_UsesHILO(id_useshilo),
      .EX_MemRead(ex_memread), .EX_RT(ex_rt), .EX_BranchTaken(ex_br),
      .PC_Write(b_pc), .IFID_Write(b_ifw), .IFID_Flush(b_iff),
      .IDEX_Flush(b_idf), .MD_Start(b_st), .MD_Busy(b_busy)
   );

   wire [5:0] a_vec = {a_pc, a_ifw, a_iff, a_idf, a_st, a_busy};
   wire [5:0] b_vec = {b_pc, b_ifw, b_iff, b_idf, b_st, b_busy};

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_muldiv = 1'b0; id_useshilo = 1'b0; ex_memread = 1'b0; ex_br = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      settle();
      check("reset_a", a_vec, V_IDLE);
      check("reset_b", b_vec, V_IDLE);

      // Load-use on rs
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
      settle();
      check("lu_rs_a", a_vec, V_STALL);
      check("lu_rs_b", b_vec, V_STALL);
      tick();
      // Load-use on rt
      id_rs = 5'd2; id_rt = 5'd8;
      settle();
      check("lu_rt", a_vec, V_STALL);
      tick();
      // Load to $zero never stalls
      ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      settle();
      check("lu_zero", a_vec, V_IDLE);
      tick();
      // Matching register but not a load
      ex_memread = 1'b0; ex_rt = 5'd8; id_rs = 5'd8;
      settle();
      check("no_load", a_vec, V_IDLE);
      tick();
      // Load with no dependency
      ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd8; id_rt = 5'd10;
      settle();
      check("lu_nomatch", a_vec, V_IDLE);
      tick();

      // Taken branch overrides load-use and suppresses mult/div launch
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_muldiv = 1'b1; ex_br = 1'b1;
      settle();
      check("br_prio_a", a_vec, V_BRANCH);
      check("br_prio_b", b_vec, V_BRANCH);
      tick();
      clear_inputs();
      settle();
      check("br_no_md", a_vec, V_IDLE);

      // Load-use blocks mult/div launch without a branch
      ex_memread = 1'b1; ex_rt = 5'd8; id_rt = 5'd8; id_muldiv = 1'b1;
      settle();
      check("lu_blocks_md", a_vec, V_STALL);
      tick();
      clear_inputs();

      // Single mult, MD_LATENCY=4: busy exactly 4 cycles
      id_muldiv = 1'b1;
      settle();
      check("md_start", a_vec, V_START);
      tick();
      id_muldiv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check($sformatf("md_busy%0d", i), a_vec, V_BUSY);
         tick();
      end
      settle();
      check("md_done", a_vec, V_IDLE);

      // mfhi arrives in 2nd wait cycle: stalled until busy falls
      do_reset();
      id_muldiv = 1'b1;
      tick();
      id_muldiv = 1'b0;
      settle();
      check("hilo_w1", a_vec, V_BUSY);
      tick();
      id_useshilo = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         settle();
         check($sformatf("hilo_stall_w%0d", i), a_vec, V_MHSTL);
         tick();
      end
      settle();
      check("hilo_proceed", a_vec, V_IDLE);
      tick();
      clear_inputs();

      // Reset in 3rd wait cycle abandons the operation
      do_reset();
      id_muldiv = 1'b1;
      tick();
      id_muldiv = 1'b0;
      tick();
      tick();
      id_useshilo = 1'b1;
      settle();
      check("rst_mid_stall", a_vec, V_MHSTL);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("rst_mid_a", a_vec, V_IDLE);
      check("rst_mid_b", b_vec, V_IDLE);
      clear_inputs();

      // Branch during wait does not abort the operation
      do_reset();
      id_muldiv = 1'b1;
      tick();
      ex_br = 1'b1;
      settle();
      check("br_in_wait", a_vec, V_BRBUSY);
      tick();
      clear_inputs();
      settle();
      check("br_wait_w2", a_vec, V_BUSY);
      tick();
      tick();
      settle();
      check("br_wait_w4", a_vec, V_BUSY);
      tick();
      settle();
      check("br_wait_done", a_vec, V_IDLE);

      // Back-to-back mult, MD_LATENCY=32
      do_reset();
      id_muldiv = 1'b1;
      settle();
      check("b2b_start1", b_vec, V_START);
      tick();
      for (int i = 0; i < 32; i++) begin
         settle();
         check($sformatf("b2b_stall%0d", i), b_vec, V_MHSTL);
         tick();
      end
      settle();
      check("b2b_start2", b_vec, V_START);
      tick();
      id_muldiv = 1'b0;
      settle();
      check("b2b_busy2", b_vec, V_BUSY);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
